// File: rtl/memory_lsu.sv
// ============================================================================
// memory_lsu : multicycle RV32I byte/half/word load-store memory with a
//              valid/ready request port, fixed access latency and fault flags.
// Revision   : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module memory_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oDone,
  output logic        oFault
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int AW    = IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              lat_write;
  logic [2:0]        lat_funct3;
  logic [AW-1:0]     lat_addr;
  logic [31:0]       lat_data;
  logic              lat_fault;

  logic              accept;
  logic              commit;
  logic              funct3_ok;
  logic              misaligned;
  logic              out_of_range;
  logic              in_fault;

  logic              eff_write;
  logic [2:0]        eff_funct3;
  logic [AW-1:0]     eff_addr;
  logic [31:0]       eff_data;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        byte_en;
  logic [31:0]       wr_lanes;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_value;

  logic [31:0]       mem [DEPTH_WORDS];

  assign accept = iValid && (state == IDLE);

  // Request classification is done on the live inputs; only the verdict is kept.
  always_comb begin
    if (iWrite) begin
      funct3_ok = (iFunct3 == 3'b000) || (iFunct3 == 3'b001) || (iFunct3 == 3'b010);
    end else begin
      funct3_ok = (iFunct3 == 3'b000) || (iFunct3 == 3'b001) || (iFunct3 == 3'b010) ||
                  (iFunct3 == 3'b100) || (iFunct3 == 3'b101);
    end
    misaligned   = ((iFunct3[1:0] == 2'b01) && iAddress[0]) ||
                   ((iFunct3[1:0] == 2'b10) && (iAddress[1:0] != 2'b00));
    out_of_range = ({2'b00, iAddress[31:2]} >= 32'(DEPTH_WORDS));
    in_fault     = !funct3_ok || misaligned || out_of_range;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_fault) begin
            state_nx = RESP;
          end else if (LATENCY == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = BUSY;
            cnt_nx   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= '0;
      lat_data   <= 32'd0;
      lat_fault  <= 1'b0;
      oData      <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_write  <= iWrite;
        lat_funct3 <= iFunct3;
        lat_addr   <= iAddress[AW-1:0];
        lat_data   <= iData;
        lat_fault  <= in_fault;
      end
      if (commit && !eff_write) begin
        oData <= ld_value;
      end
    end
  end

  // With LATENCY=1 the commit edge is also the acceptance edge, so use live inputs.
  always_comb begin
    if (state == IDLE) begin
      eff_write  = iWrite;
      eff_funct3 = iFunct3;
      eff_addr   = iAddress[AW-1:0];
      eff_data   = iData;
    end else begin
      eff_write  = lat_write;
      eff_funct3 = lat_funct3;
      eff_addr   = lat_addr;
      eff_data   = lat_data;
    end
  end

  assign idx = eff_addr[AW-1:2];

  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = eff_data;
    case (eff_funct3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << eff_addr[1:0];
        wr_lanes = {4{eff_data[7:0]}};
      end
      2'b01: begin
        byte_en  = eff_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{eff_data[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clock) begin
    if (commit && eff_write && reset_n) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*eff_addr[1:0] +: 8];
  assign rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (eff_funct3)
      3'b000:  ld_value = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_value = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_value = {24'd0, rd_byte};
      3'b101:  ld_value = {16'd0, rd_half};
      default: ld_value = rd_word;
    endcase
  end

  assign oReady = (state == IDLE);
  assign oDone  = (state == RESP);
  assign oFault = (state == RESP) && lat_fault;

endmodule

`default_nettype wire
